// File: rtl/vc_arbiter_demux_pkg.sv
// vc_arbiter_demux_pkg
// Shared definitions for the VC output stage: TL state encodings, the
// default word geometry, the in-flight stage record and a helper for the
// round-robin search order.
package vc_arbiter_demux_pkg;

  localparam int NUM_VC       = 4;
  localparam int DATA_W_DEF   = 10;
  localparam int DEST_LSB_DEF = 8;

  // Transaction-layer state machine, one-hot.
  typedef enum logic [3:0] {
    ST_RESET  = 4'b0001,
    ST_INIT   = 4'b0010,
    ST_IDLE   = 4'b0100,
    ST_ACTIVE = 4'b1000
  } tl_state_e;

  // Stage-1 record: a pop happened last cycle and which VC it came from.
  typedef struct packed {
    logic       vld;
    logic [1:0] src;
  } inflight_t;

  // k-th candidate after the last grant; 2-bit add wraps modulo 4.
  function automatic logic [1:0] rr_cand(input logic [1:0] last,
                                         input logic [1:0] k);
    return last + k;
  endfunction

endpackage

// File: rtl/vc_arbiter_demux_rr_arbiter4.sv
// rr_arbiter4
// Purely combinational 4-way round-robin arbiter. The search starts at the
// VC after 'last' and wraps; the caller owns the 'last' register.
// Ports:
//   req[3:0]     requesting VCs
//   enable       when low no grant is issued
//   last[1:0]    last granted VC
//   gnt[3:0]     one-hot grant (zero when none)
//   gnt_idx[1:0] index of the grant (0 when none)
//   gnt_valid    a grant is issued
module rr_arbiter4
  import vc_arbiter_demux_pkg::*;
(
  input  logic [3:0] req,
  input  logic       enable,
  input  logic [1:0] last,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid
);

  logic [1:0] w_cand;

  always_comb begin
    w_cand    = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    // k = 1..4; k = 4 wraps back to 'last' itself, so a lone requester
    // that was just granted is still served.
    for (int k = 1; k <= NUM_VC; k++) begin
      w_cand = rr_cand(last, k[1:0]);
      if (enable && !gnt_valid && req[w_cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = w_cand;
      end
    end
  end

  assign gnt = gnt_valid ? (4'b0001 << gnt_idx) : 4'b0000;

endmodule

// File: rtl/vc_arbiter_demux.sv
// vc_arbiter_demux
// Output stage of the VC buffering path. Pops one word per cycle from four
// input FIFOs (round robin), waits one cycle for the FIFO read data, then
// pushes the word to the output FIFO selected by data[DEST_LSB+1:DEST_LSB].
// Ports:
//   clk, reset_L          clock, async active-low reset
//   state[3:0]            TL state (one-hot); pops only in ACTIVE
//   fifo_empty[3:0]       input FIFO empty flags
//   fifo_data0..3         input FIFO read data (valid the cycle after pop)
//   out_almost_full[3:0]  output FIFO backpressure; any bit stalls pops
//   pop[3:0]              combinational pop strobes
//   push[3:0]             registered push strobes, one-hot or zero
//   data_out              registered word to the output FIFOs
//   valid_out             registered OR of push
module vc_arbiter_demux
  import vc_arbiter_demux_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DEST_LSB = DEST_LSB_DEF
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic [3:0]        state,
  input  logic [3:0]        fifo_empty,
  input  logic [DATA_W-1:0] fifo_data0,
  input  logic [DATA_W-1:0] fifo_data1,
  input  logic [DATA_W-1:0] fifo_data2,
  input  logic [DATA_W-1:0] fifo_data3,
  input  logic [3:0]        out_almost_full,
  output logic [3:0]        pop,
  output logic [3:0]        push,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out
);

  logic [NUM_VC-1:0][DATA_W-1:0] w_fifo_data;
  logic                          w_go;
  logic [3:0]                    w_gnt;
  logic [1:0]                    w_gnt_idx;
  logic                          w_gnt_valid;
  logic [DATA_W-1:0]             w_word;
  logic [1:0]                    w_dest;

  logic [1:0]        r_rr;
  inflight_t         r_infl;
  logic [3:0]        r_push;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;

  assign w_fifo_data[0] = fifo_data0;
  assign w_fifo_data[1] = fifo_data1;
  assign w_fifo_data[2] = fifo_data2;
  assign w_fifo_data[3] = fifo_data3;

  // reset_L is in the gate so pop is forced low during an asserted reset.
  assign w_go = reset_L && (state == ST_ACTIVE) && (out_almost_full == 4'b0000);

  rr_arbiter4 u_arb (
    .req       (~fifo_empty),
    .enable    (w_go),
    .last      (r_rr),
    .gnt       (w_gnt),
    .gnt_idx   (w_gnt_idx),
    .gnt_valid (w_gnt_valid)
  );

  assign pop = w_gnt;

  // FIFO read data for the word popped last cycle.
  assign w_word = w_fifo_data[r_infl.src];
  assign w_dest = w_word[DEST_LSB+1:DEST_LSB];

  // In-flight words are not gated by state or backpressure: once popped they
  // always reach the output (output FIFOs keep headroom for them).
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_rr    <= 2'd3;
      r_infl  <= '0;
      r_push  <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_gnt_valid) r_rr <= w_gnt_idx;
      r_infl.vld <= w_gnt_valid;
      r_infl.src <= w_gnt_idx;
      if (r_infl.vld) begin
        r_data  <= w_word;
        r_push  <= 4'b0001 << w_dest;
        r_valid <= 1'b1;
      end else begin
        r_push  <= '0;
        r_valid <= 1'b0;
      end
    end
  end

  assign push      = r_push;
  assign data_out  = r_data;
  assign valid_out = r_valid;

endmodule

// File: tb/tb_vc_arbiter_demux.sv
module tb_vc_arbiter_demux;
  localparam int DW = 10;

  logic          clk = 1'b0;
  logic          reset_L = 1'b1;
  logic [3:0]    state;
  logic [3:0]    fifo_empty;
  logic [DW-1:0] fd [4];
  logic [3:0]    out_almost_full;
  logic [3:0]    pop, push;
  logic [DW-1:0] data_out;
  logic          valid_out;

  vc_arbiter_demux #(.DATA_W(DW), .DEST_LSB(8)) dut (
    .clk(clk), .reset_L(reset_L), .state(state), .fifo_empty(fifo_empty),
    .fifo_data0(fd[0]), .fifo_data1(fd[1]), .fifo_data2(fd[2]), .fifo_data3(fd[3]),
    .out_almost_full(out_almost_full), .pop(pop), .push(push),
    .data_out(data_out), .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  // Input FIFO contents (emulated FIFOs with registered read data).
  logic [DW-1:0] q0[$], q1[$], q2[$], q3[$];

  int nvec = 0, nerr = 0;

  // Model: last granted VC, word popped last cycle, word at the output.
  int            m_rr = 3;
  logic          m_v1 = 1'b0;
  logic [DW-1:0] m_w1 = '0;
  logic          m_ov = 1'b0;
  logic [DW-1:0] m_ow = '0;

  logic [3:0]    pop_log[$], push_log[$];
  logic [DW-1:0] dat_log[$];

  function automatic int qsize(input int i);
    case (i)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      default: return q3.size();
    endcase
  endfunction

  function automatic logic [DW-1:0] qfront(input int i);
    case (i)
      0: return q0[0];
      1: return q1[0];
      2: return q2[0];
      default: return q3[0];
    endcase
  endfunction

  // Which VC must be popped this cycle, or -1.
  function automatic int m_pick();
    if (!reset_L || state != 4'b1000 || out_almost_full != 4'b0000) return -1;
    for (int k = 1; k <= 4; k++) begin
      if (qsize((m_rr + k) % 4) > 0) return (m_rr + k) % 4;
    end
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model advance + FIFO emulation.
  always @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      m_rr = 3; m_v1 = 1'b0; m_ov = 1'b0; m_ow = '0;
    end else begin
      int g;
      g = m_pick();
      m_ov = m_v1;
      if (m_v1) m_ow = m_w1;
      m_v1 = (g >= 0);
      if (g >= 0) begin
        m_w1 = qfront(g);
        m_rr = g;
      end
      if (pop[0]) fd[0] <= q0.pop_front();
      if (pop[1]) fd[1] <= q1.pop_front();
      if (pop[2]) fd[2] <= q2.pop_front();
      if (pop[3]) fd[3] <= q3.pop_front();
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    int g;
    logic [3:0] ep, eh;
    g  = m_pick();
    ep = (g >= 0) ? (4'b0001 << g) : 4'b0000;
    eh = m_ov ? (4'b0001 << m_ow[9:8]) : 4'b0000;
    chk("pop", pop, ep);
    chk("push", push, eh);
    chk("data_out", data_out, m_ow);
    chk("valid_out", valid_out, m_ov);
    pop_log.push_back(pop);
    push_log.push_back(push);
    dat_log.push_back(data_out);
  end

  task automatic refresh();
    fifo_empty = {q3.size() == 0, q2.size() == 0, q1.size() == 0, q0.size() == 0};
  endtask

  task automatic tick();
    @(posedge clk); #1;
    refresh();
  endtask

  task automatic put(input int i, input logic [DW-1:0] w);
    case (i)
      0: q0.push_back(w);
      1: q1.push_back(w);
      2: q2.push_back(w);
      default: q3.push_back(w);
    endcase
    refresh();
  endtask

  task automatic clr_logs();
    pop_log.delete(); push_log.delete(); dat_log.delete();
  endtask

  function automatic int npush();
    int n = 0;
    foreach (push_log[i]) if (push_log[i] != 4'b0000) n++;
    return n;
  endfunction

  initial begin
    logic [DW-1:0] rw [4];
    state = 4'b1000;
    out_almost_full = 4'b0000;
    for (int i = 0; i < 4; i++) fd[i] = '0;
    refresh();
    #1 reset_L = 1'b0;

    // Reset held with VCs loaded and ACTIVE; then fairness after release.
    for (int i = 0; i < 4; i++) begin
      put(i, {2'(i), 8'(16 * i)});
      put(i, {2'(3 - i), 8'(16 * i + 1)});
    end
    repeat (3) tick();
    @(negedge clk);
    chk("rst_pop", pop, 4'b0000);
    chk("rst_push", push, 4'b0000);
    chk("rst_data", data_out, 0);
    tick();
    reset_L = 1'b1;
    clr_logs();
    @(negedge clk);
    chk("first_pop", pop, 4'b0001);
    repeat (11) tick();
    chk("fair0", pop_log[0], 4'b0001);
    chk("fair1", pop_log[1], 4'b0010);
    chk("fair2", pop_log[2], 4'b0100);
    chk("fair3", pop_log[3], 4'b1000);
    chk("fair4", pop_log[4], 4'b0001);
    chk("fair7", pop_log[7], 4'b1000);
    chk("fair8", pop_log[8], 4'b0000);
    chk("fair_push2", push_log[2], 4'b0001);
    chk("fair_npush", npush(), 8);

    // Routing from VC2 to all four destinations.
    rw[0] = 10'h0AA; rw[1] = 10'h1AA; rw[2] = 10'h2AA; rw[3] = 10'h3AA;
    for (int k = 0; k < 4; k++) put(2, rw[k]);
    clr_logs();
    repeat (8) tick();
    for (int k = 0; k < 4; k++) begin
      chk("route_pop", pop_log[k], 4'b0100);
      chk("route_push", push_log[2 + k], 4'b0001 << k);
      chk("route_data", dat_log[2 + k], rw[k]);
    end

    // Backpressure: last grant was VC2, so VC3 then VC0 before the stall.
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 3; k++) put(i, {2'(i), 8'(8'h30 + k)});
    clr_logs();
    tick(); tick();
    out_almost_full = 4'b1000;
    @(negedge clk);
    chk("bp_pop0", pop, 4'b0000);
    repeat (3) tick();
    out_almost_full = 4'b0000;
    @(negedge clk);
    chk("bp_resume", pop, 4'b0010);
    chk("bp_pop_a", pop_log[0], 4'b1000);
    chk("bp_pop_b", pop_log[1], 4'b0001);
    chk("bp_push_a", push_log[2], 4'b1000);
    chk("bp_push_b", push_log[3], 4'b0001);
    chk("bp_push_c", push_log[4], 4'b0000);
    repeat (14) tick();

    // State gate: INIT blocks, ACTIVE pops, IDLE stops with in-flight drained.
    for (int k = 0; k < 6; k++) put(0, {2'(k % 4), 8'(8'h50 + k)});
    state = 4'b0010;
    clr_logs();
    repeat (3) tick();
    state = 4'b1000;
    repeat (2) tick();
    state = 4'b0100;
    repeat (4) tick();
    chk("gate_init", pop_log[0] | pop_log[1] | pop_log[2], 4'b0000);
    chk("gate_act", pop_log[3], 4'b0001);
    chk("gate_idle", pop_log[5], 4'b0000);
    chk("gate_npush", npush(), 2);
    state = 4'b1000;
    repeat (8) tick();

    // Wrap: VC3 granted twice, then VC0.
    put(3, 10'h1E0); put(3, 10'h2E1);
    tick(); tick();
    put(0, 10'h3E2);
    @(negedge clk);
    chk("wrap", pop, 4'b0001);
    repeat (4) tick();

    // Reset in cycle N+1: popped word is dropped, rr returns to 3.
    put(1, 10'h2C5);
    @(negedge clk);
    chk("mid_pop", pop, 4'b0010);
    tick();
    reset_L = 1'b0;
    clr_logs();
    repeat (3) tick();
    chk("mid_npush", npush(), 0);
    reset_L = 1'b1;
    put(0, 10'h011); put(2, 10'h122);
    @(negedge clk);
    chk("mid_rr", pop, 4'b0001);
    repeat (6) tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/vc_arbiter_demux.md
# vc_arbiter_demux

Output stage of the transaction-layer VC buffering path. Sits directly downstream of the four per-virtual-channel input FIFOs: it pops one 10-bit word per cycle using round-robin arbitration and routes it, by the destination field in bits [9:8], to one of four output FIFOs. Output FIFO `almost_full` flags provide backpressure. The block is gated by the transaction-layer state machine state.

## Interface
- `DATA_W`, 10, word width; must match the FIFO width.
- `DEST_LSB`, 8, LSB of the 2-bit destination field (`data[DEST_LSB+1:DEST_LSB]`).

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_L`  in  1  asynchronous, active-low reset.
- `state`  in  4  TL state machine state, one-hot: RESET 0001, INIT 0010, IDLE 0100, ACTIVE 1000.
- `fifo_empty`  in  4  `empty` flags of input FIFOs VC0..VC3.
- `fifo_data0`..`fifo_data3`  in  DATA_W each  `data_out` of input FIFOs VC0..VC3.
- `out_almost_full`  in  4  `almost_full` flags of output FIFOs D0..D3.
- `pop`  out  4  one-hot or zero pop strobes to the input FIFOs; combinational.
- `push`  out  4  one-hot or zero push strobes to the output FIFOs; registered.
- `data_out`  out  DATA_W  word to the output FIFOs; registered.
- `valid_out`  out  1  OR of `push`; registered.

## Operation
- Eligibility: `eligible[i] = !fifo_empty[i]`.
- Gate: `go = reset_L && state==ACTIVE && out_almost_full==4'b0000`. Any single almost_full stalls all pops.
- Grant:
  - When `go` is true and any VC is eligible, exactly one `pop[i]` is driven high.
  - Search order starts at `rr_q+1` and wraps modulo 4.
  - `rr_q` (2 bits) holds the last granted VC. It updates to `i` on each grant and holds otherwise.
- In-flight tracking: stage-1 registers `v1_q` and `src1_q` capture the grant each cycle (`v1_q <= |pop`).
- Data capture:
  - When `v1_q` is set, the block selects `fifo_data[src1_q]` and decodes `dest = word[DEST_LSB+1:DEST_LSB]`.
  - It then loads `data_out <= word` and `push <= 1<<dest`.
  - Otherwise it loads `push <= 0` and `data_out` holds its value.
- Leaving ACTIVE: no new pops. Words already in flight, up to 2, still complete their push.
- Stall while in flight: if `almost_full` rises, in-flight words are still pushed. Output FIFO thresholds must reserve at least 3 free slots.
- Reset, asynchronous and honoured mid-operation:
  - Forced values: `pop`=0, `push`=0, `data_out`=0, `valid_out`=0, `v1_q`=0, `src1_q`=0.
  - `rr_q`=3, so VC0 is granted first.
  - In-flight words are discarded.

## Timing
- Cycle N: `pop[i]` is high. The FIFO advances `rd_ptr` and updates `empty` at the end of N.
- Cycle N+1: `fifo_data_i` holds the popped word, and the block samples it at the end of N+1.
- Cycle N+2: `push[dest]` and `data_out` are valid for exactly one cycle.
- Latency from pop to push is 2 cycles. Throughput is 1 word/cycle, and back-to-back grants are allowed.
- A FIFO holding one word is popped once. Its `empty` is registered at the same edge, so no double pop occurs.
- `pop` depends combinationally on `fifo_empty`, `out_almost_full` and `state`. There is no combinational path from inputs to `push` or `data_out`.

## Structure
- Shared include `pcie_tl_defs.vh`: state encodings (`ST_RESET`, `ST_INIT`, `ST_IDLE`, `ST_ACTIVE`), `DATA_W`, `NUM_VC`=4, `DEST_LSB`. The FIFO and the SM use the same file.
- One sub-module, `rr_arbiter4`:
  - Inputs: `req[3:0]`, `enable`, `last[1:0]`.
  - Outputs: `gnt[3:0]`, `gnt_idx[1:0]`, `gnt_valid`.
  - Purely combinational. The `rr_q` register lives in the parent.

## Test plan
- **Reset:** hold `reset_L`=0 with VCs non-empty and state ACTIVE → `pop`=0, `push`=0, `data_out`=0. Release → first `pop`=0001.
- **Fairness:** all 4 VCs hold 2 words, no backpressure, ACTIVE → `pop` sequence is 0001, 0010, 0100, 1000, 0001, 0010, 0100, 1000, then 0. Eight pushes follow, each 2 cycles after its pop.
- **Routing:** VC2 holds 10'h0AA, 10'h1AA, 10'h2AA, 10'h3AA → `push` is 0001, 0010, 0100, 1000 on consecutive cycles with matching `data_out`.
- **Backpressure:** set `out_almost_full[3]`=1 while popping → `pop` drops to 0 the same cycle. The 2 in-flight words are still pushed. Clear the flag → popping resumes from `rr_q+1`.
- **State gate and wrap:**
  - With VC0 only non-empty: state INIT → no pops; ACTIVE → pops; switch to IDLE mid-burst → pops stop and in-flight pushes complete.
  - Repeated VC3 grants followed by a VC0 request → the arbiter wraps to VC0.
- **Reset mid-flight:** assert `reset_L`=0 in cycle N+1 after a pop → no push occurs, and `rr_q` returns to 3.
